// File: rtl/alu_resp_unit.sv
// Valid/ready ALU responder: results are computed at accept time and queued in an in-order response FIFO.
// Optional statistics counters are enabled with `define ALU_RESP_STATS_EN.
module alu_resp_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [DATA_WIDTH-1:0] req_a,
  input  logic [DATA_WIDTH-1:0] req_b,
  input  logic [2:0]            req_op,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_result,
  output logic                  resp_overflow,
  output logic                  resp_carryout,
  output logic                  resp_zero,
`ifdef ALU_RESP_STATS_EN
  output logic                  resp_illegal,
  output logic [15:0]           illegal_cnt,
  output logic [31:0]           op_cnt
`else
  output logic                  resp_illegal
`endif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int EW = DATA_WIDTH + 4;
  localparam logic [AW:0]   DEPTH_C   = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  // Entry layout: {result, overflow, carryout, zero, illegal}
  function automatic logic [EW-1:0] alu_eval(input logic [DATA_WIDTH-1:0] a,
                                             input logic [DATA_WIDTH-1:0] b,
                                             input logic [2:0]            op);
    logic [DATA_WIDTH:0]          ext;
    logic [DATA_WIDTH-1:0]        res;
    logic signed [DATA_WIDTH-1:0] sa;
    logic signed [DATA_WIDTH-1:0] sb;
    logic                         ovf;
    logic                         cout;
    logic                         ill;
    ext  = '0;
    res  = '0;
    sa   = a;
    sb   = b;
    ovf  = 1'b0;
    cout = 1'b0;
    ill  = 1'b0;
    case (op)
      OP_AND: res = a & b;
      OP_OR:  res = a | b;
      OP_ADD: begin
        ext  = {1'b0, a} + {1'b0, b};
        res  = ext[DATA_WIDTH-1:0];
        cout = ext[DATA_WIDTH];
        ovf  = (a[DATA_WIDTH-1] == b[DATA_WIDTH-1]) && (res[DATA_WIDTH-1] != a[DATA_WIDTH-1]);
      end
      OP_SUB: begin
        // The extra bit of an unsigned subtraction is the borrow, i.e. A < B unsigned.
        ext  = {1'b0, a} - {1'b0, b};
        res  = ext[DATA_WIDTH-1:0];
        cout = ext[DATA_WIDTH];
        ovf  = (a[DATA_WIDTH-1] != b[DATA_WIDTH-1]) && (res[DATA_WIDTH-1] != a[DATA_WIDTH-1]);
      end
      OP_SLT: res = {{(DATA_WIDTH-1){1'b0}}, (sa < sb)};
      default: ill = 1'b1;
    endcase
    return {res, ovf, cout, (res == '0), ill};
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [EW-1:0]   mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count;
  logic            rdy_q;
  logic            vld_p0;
  logic            pop;
  logic [EW-1:0]   entry_p0;
  logic [EW-1:0]   head;

  assign req_ready  = rdy_q && (count < DEPTH_C);
  assign resp_valid = (count != '0);
  assign vld_p0     = req_valid && req_ready;
  assign pop        = resp_valid && resp_ready;
  assign entry_p0   = alu_eval(req_a, req_b, req_op);

  // Stage p0 -> FIFO storage: control state
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      rdy_q  <= 1'b0;
    end else begin
      rdy_q <= 1'b1;
      if (vld_p0) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)    rd_ptr <= rd_ptr + PTR_ONE;
      case ({vld_p0, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (vld_p0) mem[wr_ptr] <= entry_p0;
  end

  // FIFO head: outputs forced to zero while nothing is buffered
  assign head          = mem[rd_ptr];
  assign resp_result   = resp_valid ? head[EW-1:4] : '0;
  assign resp_overflow = resp_valid & head[3];
  assign resp_carryout = resp_valid & head[2];
  assign resp_zero     = resp_valid & head[1];
  assign resp_illegal  = resp_valid & head[0];

`ifdef ALU_RESP_STATS_EN
  always_ff @(posedge clk) begin
    if (!resetn) begin
      op_cnt      <= '0;
      illegal_cnt <= '0;
    end else if (vld_p0) begin
      op_cnt <= op_cnt + 32'd1;
      if (entry_p0[0]) illegal_cnt <= sat_inc16(illegal_cnt);
    end
  end
`endif

endmodule
